bf16_acc_sequencer: RTL

BF16_ACC_SEQUENCER -- requirements
Module: bf16_acc_sequencer

---
 rtl/bf16_acc_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/bf16_acc_sequencer.sv
// bf16_acc_sequencer
//
// Queues arithmetic requests in a small FIFO and issues them one at a time to
// one of three execution units (conv, maxmin, addmul). It waits for the unit to
// complete, or aborts after a bounded number of cycles. It then returns the
// result in request order and accumulates exception flags into a sticky
// register.
//
// Handshake rule for both req_* and resp_*: a transfer occurs on a rising clk
// edge where valid && ready are both high. A producer holding valid keeps its
// payload stable until that edge. req_ready does not depend on req_valid.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op, req_a/b/c          operation code and operands
//   resp_valid/resp_ready      response handshake
//   resp_result/flags/err      response payload, flags = {NV,DZ,OF,UF,NX}
//   unit_start, unit_sel,      issue port (sel 0 conv, 1 maxmin, 2 addmul)
//   unit_op, unit_a/b/c
//   unit_done, unit_result,    completion port
//   unit_flags
//   fflags, fflags_clr         sticky accumulated flags and synchronous clear
//   dbg_state                  current FSM state (0 IDLE,1 ISSUE,2 WAIT,3 RESP)
module bf16_acc_sequencer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [DATA_W-1:0] req_c,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic [4:0]        resp_flags,
    output logic              resp_err,
    output logic              unit_start,
    output logic [1:0]        unit_sel,
    output logic [3:0]        unit_op,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic [DATA_W-1:0] unit_c,
    input  logic              unit_done,
    input  logic [DATA_W-1:0] unit_result,
    input  logic [4:0]        unit_flags,
    output logic [4:0]        fflags,
    input  logic              fflags_clr,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [4:0]        flg_q, flg_d;
    logic              err_q, err_d;
    logic [4:0]        fflags_q, fflags_d;
    // Holds req_ready low until the first edge after reset is released.
    logic              rdy_q;

    logic [3:0]        op_mem [DEPTH];
    logic [DATA_W-1:0] a_mem  [DEPTH];
    logic [DATA_W-1:0] b_mem  [DEPTH];
    logic [DATA_W-1:0] c_mem  [DEPTH];

    logic              push, pop;
    logic [3:0]        head_op;
    logic              head_legal;
    logic [1:0]        head_sel;

    assign req_ready = rdy_q && (count_q != CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_RESP) && resp_ready;

    assign head_op    = op_mem[rd_ptr_q];
    assign head_legal = (head_op <= 4'd10);

    always_comb begin
        if (head_op <= 4'd1)      head_sel = 2'd0;
        else if (head_op <= 4'd3) head_sel = 2'd1;
        else                      head_sel = 2'd2;
    end

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= req_op;
            a_mem[wr_ptr_q]  <= req_a;
            b_mem[wr_ptr_q]  <= req_b;
            c_mem[wr_ptr_q]  <= req_c;
        end
    end

    // FSM next state and issue-port outputs.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        res_d      = res_q;
        flg_d      = flg_q;
        err_d      = err_q;
        unit_start = 1'b0;
        unit_sel   = 2'd0;
        unit_op    = 4'd0;
        unit_a     = '0;
        unit_b     = '0;
        unit_c     = '0;

        if (state_q == S_ISSUE || state_q == S_WAIT) begin
            unit_sel = head_sel;
            unit_op  = head_op;
            unit_a   = a_mem[rd_ptr_q];
            unit_b   = b_mem[rd_ptr_q];
            unit_c   = c_mem[rd_ptr_q];
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (head_legal) begin
                    unit_start = 1'b1;
                    to_cnt_d   = '0;
                    state_d    = S_WAIT;
                end else begin
                    // Illegal opcode: answer locally with an invalid-operation flag.
                    res_d   = '0;
                    flg_d   = 5'b10000;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a timeout expiring in the same cycle.
                if (unit_done) begin
                    res_d   = unit_result;
                    flg_d   = unit_flags;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    flg_d   = 5'b00000;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    // count_q >= 1 here; entries remain if more than the head is stored
                    // or a new request is being accepted in this same cycle.
                    state_d = (count_q != CNT_W'(1) || push) ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky flags: a clear coinciding with a handshake keeps only the new flags.
    always_comb begin
        fflags_d = fflags_q;
        if (pop)             fflags_d = (fflags_clr ? 5'b00000 : fflags_q) | flg_q;
        else if (fflags_clr) fflags_d = 5'b00000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            to_cnt_q <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            err_q    <= 1'b0;
            fflags_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            to_cnt_q <= to_cnt_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            err_q    <= err_d;
            fflags_q <= fflags_d;
            rdy_q    <= 1'b1;
        end
    end

    assign resp_valid  = (state_q == S_RESP);
    assign resp_result = resp_valid ? res_q : '0;
    assign resp_flags  = resp_valid ? flg_q : 5'b00000;
    assign resp_err    = resp_valid && err_q;
    assign fflags      = fflags_q;
    assign dbg_state   = state_q;

endmodule
